// File: rtl/packer_pkg.sv
// Shared types and helpers for the bitstream packer: word geometry, the FIFO
// entry layout and byte-boundary rounding.
package packer_pkg;

  localparam int WORD_W = 64;
  localparam int BYTE_W = 8;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  bytes;
    logic        last;
  } packer_entry_t;

  // Round a residue length (0..63) up to the next multiple of BYTE_W.
  function automatic logic [6:0] pad_to_byte(input logic [6:0] n);
    logic [6:0] w_sum;
    w_sum = n + 7'd7;
    return {w_sum[6:3], 3'b000};
  endfunction

endpackage

// File: rtl/packer_fifo.sv
// Output word FIFO. Writes up to two entries per cycle, in lane order, and
// reads one. Occupancy is tracked with a count so full and empty never alias.
module packer_fifo
  import packer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [1:0]               i_wr_cnt,
  input  packer_entry_t            i_wr_lane0,
  input  packer_entry_t            i_wr_lane1,
  input  logic                     i_rd_en,
  output packer_entry_t            o_head,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  packer_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic [AW-1:0] w_wptr_p1;
  logic          w_pop;

  assign w_wptr_p1 = r_wptr + PTR_ONE;
  assign w_pop     = i_rd_en && (r_count != '0);

  // Storage is not reset; the head is only meaningful while o_valid is high.
  always_ff @(posedge clock) begin
    if (i_wr_cnt != 2'd0) begin
      r_mem[r_wptr] <= i_wr_lane0;
    end
    if (i_wr_cnt == 2'd2) begin
      r_mem[w_wptr_p1] <= i_wr_lane1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(i_wr_cnt);
      r_rptr  <= r_rptr + AW'(w_pop);
      r_count <= r_count + (AW+1)'(i_wr_cnt) - (AW+1)'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_valid = (r_count != '0);
  assign o_free  = CNT_DEPTH - r_count;

endmodule

// File: rtl/bitstream_packer.sv
// Packs variable-length fields MSB-first into 64-bit big-endian words,
// queues them for a downstream writer and keeps a running bit count.
module bitstream_packer
  import packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             input_enable,
  input  logic [63:0]      val,
  input  logic [63:0]      size_of_bit,
  input  logic             flush_bit,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [63:0]      out_data,
  output logic [3:0]       out_bytes,
  output logic             out_last,
  output logic [CNT_W-1:0] total_bits,
  output logic             overflow,
  output logic             size_error
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Output handshake: out_valid means the head entry is present and stable;
  // the head is consumed on any clock edge where out_valid && out_ready.

  logic [63:0]      r_acc;
  logic [5:0]       r_acc_n;
  logic [CNT_W-1:0] r_total_bits;
  logic             r_overflow;
  logic             r_size_error;

  logic             w_size_big;
  logic [6:0]       w_s;
  logic [63:0]      w_mask;
  logic [63:0]      w_val_m;
  logic [6:0]       w_sum;
  logic [7:0]       w_shamt;
  logic [127:0]     w_comb;
  logic             w_full;
  logic [6:0]       w_r;
  logic [63:0]      w_residue;
  logic [6:0]       w_padded;
  logic             w_flush_word;
  logic [6:0]       w_pad_bits;
  logic [1:0]       w_wr_req;
  logic [1:0]       w_wr_cnt;
  logic             w_drop;
  logic             w_pop;
  logic [AW:0]      w_free;
  logic [AW:0]      w_free_eff;
  packer_entry_t    w_lane0;
  packer_entry_t    w_lane1;
  packer_entry_t    w_head;
  logic             w_fifo_valid;

  assign w_size_big = (size_of_bit > 64'd64);
  assign w_s        = w_size_big ? 7'd64 : size_of_bit[6:0];
  assign w_mask     = (w_s == 7'd64) ? '1 : ((64'd1 << w_s) - 64'd1);
  assign w_val_m    = val & w_mask;

  // The new field lands directly behind the held bits in a 128-bit window,
  // so the upper half is always the next full word when the sum reaches 64.
  assign w_sum   = {1'b0, r_acc_n} + w_s;
  assign w_shamt = 8'd128 - {1'b0, w_sum};
  assign w_comb  = {r_acc, 64'd0} | ({64'd0, w_val_m} << w_shamt);

  assign w_full    = w_sum[6];
  assign w_r       = {1'b0, w_sum[5:0]};
  assign w_residue = w_full ? w_comb[63:0] : w_comb[127:64];

  assign w_padded     = pad_to_byte(w_r);
  assign w_flush_word = flush_bit && (w_padded != 7'd0);
  assign w_pad_bits   = flush_bit ? (w_padded - w_r) : 7'd0;

  always_comb begin
    w_wr_req = 2'd0;
    if (input_enable) begin
      w_wr_req = {1'b0, w_full} + {1'b0, w_flush_word};
    end
  end

  always_comb begin
    w_lane1.data  = w_residue;
    w_lane1.bytes = w_padded[6:3];
    w_lane1.last  = 1'b1;
    if (w_full) begin
      w_lane0.data  = w_comb[127:64];
      w_lane0.bytes = 4'd8;
      w_lane0.last  = 1'b0;
    end else begin
      w_lane0 = w_lane1;
    end
  end

  // A same-edge pop frees its slot before deciding how many words fit.
  assign w_pop      = w_fifo_valid && out_ready;
  assign w_free_eff = w_free + (AW+1)'(w_pop);
  assign w_drop     = ((AW+1)'(w_wr_req) > w_free_eff);
  assign w_wr_cnt   = w_drop ? w_free_eff[1:0] : w_wr_req;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc        <= '0;
      r_acc_n      <= '0;
      r_total_bits <= '0;
      r_overflow   <= 1'b0;
      r_size_error <= 1'b0;
    end else begin
      if (input_enable) begin
        if (flush_bit) begin
          r_acc   <= '0;
          r_acc_n <= '0;
        end else begin
          r_acc   <= w_residue;
          r_acc_n <= w_r[5:0];
        end
        r_total_bits <= r_total_bits + CNT_W'(w_s) + CNT_W'(w_pad_bits);
        if (w_size_big) begin
          r_size_error <= 1'b1;
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  packer_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_wr_cnt   (w_wr_cnt),
    .i_wr_lane0 (w_lane0),
    .i_wr_lane1 (w_lane1),
    .i_rd_en    (w_pop),
    .o_head     (w_head),
    .o_valid    (w_fifo_valid),
    .o_free     (w_free)
  );

  assign out_valid  = w_fifo_valid;
  assign out_data   = w_fifo_valid ? w_head.data  : 64'd0;
  assign out_bytes  = w_fifo_valid ? w_head.bytes : 4'd0;
  assign out_last   = w_fifo_valid ? w_head.last  : 1'b0;
  assign total_bits = r_total_bits;
  assign overflow   = r_overflow;
  assign size_error = r_size_error;

endmodule

// File: tb/tb_bitstream_packer.sv
// Directed bench for bitstream_packer: header packing, flushes, straddling
// fields, FIFO backpressure/overflow, size errors and asynchronous reset.
module tb_bitstream_packer;
  import packer_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        input_enable;
  logic [63:0] val;
  logic [63:0] size_of_bit;
  logic        flush_bit;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic [3:0]  out_bytes;
  logic        out_last;
  logic [63:0] total_bits;
  logic        overflow;
  logic        size_error;

  int total;
  int bad;
  logic [63:0] exp_q[$];

  bitstream_packer #(
    .FIFO_DEPTH (16),
    .CNT_W      (64)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .input_enable (input_enable),
    .val          (val),
    .size_of_bit  (size_of_bit),
    .flush_bit    (flush_bit),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_bytes    (out_bytes),
    .out_last     (out_last),
    .total_bits   (total_bits),
    .overflow     (overflow),
    .size_error   (size_error)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic do_reset();
    reset_n      = 1'b0;
    input_enable = 1'b0;
    val          = '0;
    size_of_bit  = '0;
    flush_bit    = 1'b0;
    out_ready    = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // driver tasks
  task automatic send(input logic [63:0] v, input logic [63:0] s, input logic f);
    @(negedge clock);
    input_enable = 1'b1;
    val          = v;
    size_of_bit  = s;
    flush_bit    = f;
    @(posedge clock);
    #1;
    input_enable = 1'b0;
    flush_bit    = 1'b0;
  endtask

  task automatic pop_word(output logic [63:0] d, output logic [3:0] b, output logic l);
    int waited;
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(posedge clock);
      #1;
      waited++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL pop_timeout: out_valid=%b want 1", out_valid);
    end
    d = out_data;
    b = out_bytes;
    l = out_last;
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    if (out_data !== 64'd0) begin bad++; $display("FAIL rst_data: got %h want 0", out_data); end
    if (total_bits !== 64'd0) begin bad++; $display("FAIL rst_total: got %0d want 0", total_bits); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    if (size_error !== 1'b0) begin bad++; $display("FAIL rst_size_error: got %b want 0", size_error); end
    do_reset();
  endtask

  task automatic test_header();
    logic [63:0] d;
    logic [3:0]  b;
    logic        l;
    do_reset();
    send(64'h0, 64'd32, 1'b0);
    send(64'h6963_7066, 64'd32, 1'b0);
    total += 2;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL hdr_valid: got %b want 1", out_valid); end
    if (total_bits !== 64'd64) begin bad++; $display("FAIL hdr_total: got %0d want 64", total_bits); end
    pop_word(d, b, l);
    total += 4;
    if (d !== 64'h0000_0000_6963_7066) begin bad++; $display("FAIL hdr_data: got %h want 0000000069637066", d); end
    if (b !== 4'd8) begin bad++; $display("FAIL hdr_bytes: got %0d want 8", b); end
    if (l !== 1'b0) begin bad++; $display("FAIL hdr_last: got %b want 0", l); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL hdr_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_short_flush();
    logic [63:0] d;
    logic [3:0]  b;
    logic        l;
    do_reset();
    send(64'h5, 64'd3, 1'b1);
    total++;
    if (total_bits !== 64'd8) begin bad++; $display("FAIL sf_total: got %0d want 8", total_bits); end
    pop_word(d, b, l);
    total += 3;
    if (d !== 64'hA000_0000_0000_0000) begin bad++; $display("FAIL sf_data: got %h want a000000000000000", d); end
    if (b !== 4'd1) begin bad++; $display("FAIL sf_bytes: got %0d want 1", b); end
    if (l !== 1'b1) begin bad++; $display("FAIL sf_last: got %b want 1", l); end
    // zero-size field without flush changes nothing; with flush it drains the residue
    send(64'h3, 64'd2, 1'b0);
    send(64'hFFFF, 64'd0, 1'b0);
    total += 2;
    if (total_bits !== 64'd10) begin bad++; $display("FAIL s0_total: got %0d want 10", total_bits); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL s0_valid: got %b want 0", out_valid); end
    send(64'h0, 64'd0, 1'b1);
    pop_word(d, b, l);
    total += 3;
    if (d !== 64'hC000_0000_0000_0000) begin bad++; $display("FAIL s0f_data: got %h want c000000000000000", d); end
    if (b !== 4'd1) begin bad++; $display("FAIL s0f_bytes: got %0d want 1", b); end
    if (total_bits !== 64'd16) begin bad++; $display("FAIL s0f_total: got %0d want 16", total_bits); end
    send(64'hA_BCDE, 64'd20, 1'b1);
    pop_word(d, b, l);
    total += 3;
    if (d !== 64'hABCD_E000_0000_0000) begin bad++; $display("FAIL f20_data: got %h want abcde00000000000", d); end
    if (b !== 4'd3) begin bad++; $display("FAIL f20_bytes: got %0d want 3", b); end
    if (total_bits !== 64'd40) begin bad++; $display("FAIL f20_total: got %0d want 40", total_bits); end
  endtask

  task automatic test_straddle_flush();
    logic [63:0] d;
    logic [3:0]  b;
    logic        l;
    do_reset();
    send(64'h0FFF_FFFF_FFFF_FFFF, 64'd60, 1'b0);
    send(64'hAB, 64'd8, 1'b1);
    total++;
    if (total_bits !== 64'd72) begin bad++; $display("FAIL st_total: got %0d want 72", total_bits); end
    pop_word(d, b, l);
    total += 3;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFA) begin bad++; $display("FAIL st_w0_data: got %h want fffffffffffffffa", d); end
    if (b !== 4'd8) begin bad++; $display("FAIL st_w0_bytes: got %0d want 8", b); end
    if (l !== 1'b0) begin bad++; $display("FAIL st_w0_last: got %b want 0", l); end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL st_w1_valid: got %b want 1", out_valid); end
    pop_word(d, b, l);
    total += 3;
    if (d !== 64'hB000_0000_0000_0000) begin bad++; $display("FAIL st_w1_data: got %h want b000000000000000", d); end
    if (b !== 4'd1) begin bad++; $display("FAIL st_w1_bytes: got %0d want 1", b); end
    if (l !== 1'b1) begin bad++; $display("FAIL st_w1_last: got %b want 1", l); end
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    logic [3:0]  b;
    logic        l;
    logic [63:0] w;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      w = 64'hC0DE_0000_0000_0000 | 64'(i);
      send(w, 64'd64, 1'b0);
      if (i < 16) exp_q.push_back(w);
      if (i == 15) begin
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL bp_ovf_at16: got %b want 0", overflow); end
      end
    end
    total += 2;
    if (overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf_at17: got %b want 1", overflow); end
    if (total_bits !== 64'd1088) begin bad++; $display("FAIL bp_total: got %0d want 1088", total_bits); end
    for (int i = 0; i < 16; i++) begin
      pop_word(d, b, l);
      w = exp_q.pop_front();
      total++;
      if (d !== w || b !== 4'd8) begin
        bad++;
        $display("FAIL bp_drain%0d: got %h/%0d want %h/8", i, d, b, w);
      end
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_push_pop_full();
    logic [63:0] d;
    logic [3:0]  b;
    logic        l;
    logic [63:0] w;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      w = 64'h5A5A_0000_0000_0000 | 64'(i);
      send(w, 64'd64, 1'b0);
      if (i > 0) exp_q.push_back(w);
    end
    // head pops in the same edge the 17th word arrives, so nothing is lost
    @(negedge clock);
    out_ready    = 1'b1;
    input_enable = 1'b1;
    val          = 64'h5A5A_0000_0000_0010;
    size_of_bit  = 64'd64;
    @(posedge clock);
    #1;
    out_ready    = 1'b0;
    input_enable = 1'b0;
    exp_q.push_back(64'h5A5A_0000_0000_0010);
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL pp_ovf: got %b want 0", overflow); end
    for (int i = 0; i < 16; i++) begin
      pop_word(d, b, l);
      w = exp_q.pop_front();
      total++;
      if (d !== w) begin bad++; $display("FAIL pp_drain%0d: got %h want %h", i, d, w); end
    end
  endtask

  task automatic test_size_error();
    logic [63:0] d;
    logic [3:0]  b;
    logic        l;
    do_reset();
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd70, 1'b0);
    total += 2;
    if (size_error !== 1'b1) begin bad++; $display("FAIL se_flag: got %b want 1", size_error); end
    if (total_bits !== 64'd64) begin bad++; $display("FAIL se_total: got %0d want 64", total_bits); end
    pop_word(d, b, l);
    total++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF || b !== 4'd8) begin bad++; $display("FAIL se_word: got %h/%0d want ffffffffffffffff/8", d, b); end
    send(64'hFF, 64'd4, 1'b0);
    send(64'h0, 64'd4, 1'b1);
    pop_word(d, b, l);
    total += 3;
    if (d !== 64'hF000_0000_0000_0000) begin bad++; $display("FAIL mask_data: got %h want f000000000000000", d); end
    if (b !== 4'd1) begin bad++; $display("FAIL mask_bytes: got %0d want 1", b); end
    if (total_bits !== 64'd72) begin bad++; $display("FAIL mask_total: got %0d want 72", total_bits); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    logic [3:0]  b;
    logic        l;
    do_reset();
    for (int i = 0; i < 3; i++) send(64'h1234_5678_9ABC_DEF0, 64'd64, 1'b0);
    send(64'hA_BCDE, 64'd20, 1'b0);
    total += 2;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL rm_pre_valid: got %b want 1", out_valid); end
    if (total_bits !== 64'd212) begin bad++; $display("FAIL rm_pre_total: got %0d want 212", total_bits); end
    #2;
    reset_n = 1'b0;
    #1;
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b want 0", out_valid); end
    if (total_bits !== 64'd0) begin bad++; $display("FAIL rm_total: got %0d want 0", total_bits); end
    #2;
    reset_n = 1'b1;
    send(64'h1, 64'd1, 1'b1);
    pop_word(d, b, l);
    total += 4;
    if (d !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL rm_data: got %h want 8000000000000000", d); end
    if (b !== 4'd1) begin bad++; $display("FAIL rm_bytes: got %0d want 1", b); end
    if (l !== 1'b1) begin bad++; $display("FAIL rm_last: got %b want 1", l); end
    if (total_bits !== 64'd8) begin bad++; $display("FAIL rm_post_total: got %0d want 8", total_bits); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    input_enable = 1'b0;
    val          = '0;
    size_of_bit  = '0;
    flush_bit    = 1'b0;
    out_ready    = 1'b0;
    test_reset();
    test_header();
    test_short_flush();
    test_straddle_flush();
    test_backpressure();
    test_push_pop_full();
    test_size_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitstream_packer.md
Name: bitstream_packer

Overview:
- Downstream neighbour of the frame header, picture header and slice field generators. Consumes their (enable, val, size_of_bit, flush_bit) field stream and packs variable-length fields MSB-first into 64-bit big-endian words.
- Buffers packed words in a small FIFO for the memory/stream writer, using a valid/ready handshake on the output side.
- Keeps a running bit count, which is used later to patch frame_size.

Parameters:
- FIFO_DEPTH, 16, number of 64-bit entries in the output FIFO; power of two, minimum 4.
- CNT_W, 64, width of the total_bits counter.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- input_enable  in  1  field valid. Producers have no backpressure, so one field can arrive every cycle.
- val  in  64  field value, right-aligned. Bits at index size_of_bit and above are ignored (masked).
- size_of_bit  in  64  field length in bits, 0..64.
- flush_bit  in  1  after appending this field, pad with zeros to the next byte boundary and emit the residual word.
- out_ready  in  1  downstream accepts the head word.
- out_valid  out  1  FIFO not empty.
- out_data  out  64  head word. The first stream bit is at bit 63.
- out_bytes  out  4  number of valid bytes in the head word, 1..8.
- out_last  out  1  head word was produced by a flush.
- total_bits  out  CNT_W  bits accepted since reset, including flush padding.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- size_error  out  1  sticky: a field arrived with size_of_bit > 64.

Behaviour:
- Reset (asynchronous, active-low): every output and the accumulator go to 0 and the FIFO empties. This applies mid-stream too; any partial accumulator content is discarded.
- Internal state: accumulator acc (64 bits, left-aligned) and fill count acc_n (0..63).
- Field acceptance, on a rising edge with input_enable=1:
  - Effective size s = min(size_of_bit, 64). If size_of_bit > 64, set size_error.
  - Append the low s bits of val behind the acc_n bits already held. The combined length is acc_n+s, at most 127.
  - If acc_n+s ≥ 64: write the top 64 bits as a full word (out_bytes=8, out_last=0). The residue of r = acc_n+s-64 bits becomes the new acc.
  - If flush_bit=1: pad the remaining bits with zeros up to the next multiple of 8. If the padded residue is non-empty, write it as a word with out_bytes = padded_bits/8 and out_last=1, then set acc_n=0. An empty residue writes nothing extra.
  - total_bits increases by s plus the pad bits.
- s=0 with flush_bit=0 is a no-op. s=0 with flush_bit=1 flushes the existing residue.
- Each accepted field writes 0, 1 or 2 words in the same edge. A 2-word write occurs when the accumulator crosses 64 bits and the field also flushes. Word order is full word first, then flush word.
- Latency: a word written at edge E is visible at the FIFO head (out_valid=1) immediately after E when the FIFO was empty.
- Output handshake: the head pops on any edge with out_valid & out_ready. Push and pop in the same edge are allowed. The FIFO data path is not registered on the read side; out_data, out_bytes and out_last are driven directly from the head entry.
- Full FIFO:
  - If free slots are fewer than the words to write, write as many as fit in order, drop the rest and set overflow.
  - A pop in the same edge frees its slot before the free-slot check.
  - acc and total_bits still update as if nothing was dropped.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an occupancy count, 0..FIFO_DEPTH.
- Sticky flags clear only on reset.

Decomposition:
- Package packer_pkg holds:
  - WORD_W=64, BYTE_W=8;
  - typedef packer_entry_t {logic [63:0] data; logic [3:0] bytes; logic last;};
  - function pad_to_byte(n).
- Sub-module packer_fifo: FIFO_DEPTH entries of packer_entry_t, a dual-lane write port (wr_cnt 0..2), a single read port, and a free-slot count output.
- Top level: accumulator/shift logic, counters and flags.

Test Plan:
- Header start: fields (0,32), (0x69637066,32) on consecutive cycles → one word 0x00000000_69637066, bytes=8, last=0; total_bits=64.
- Short flush: (0x5,3,flush=1) → word 0xA000000000000000, bytes=1, last=1; total_bits=8.
- Straddle plus flush: 60 bits of 0xFFF_FFFF_FFFF_FFFF, then (0xAB,8,flush=1) → same edge writes 0xFFFFFFFFFFFFFFFA (bytes=8) then 0xB000000000000000 (bytes=1, last=1); total_bits=72.
- Backpressure: out_ready=0, stream FIFO_DEPTH+1 full words → FIFO holds the first 16, the 17th is dropped, overflow=1. Raising out_ready drains the 16 in order.
- Size error and masking: (val=all ones, size_of_bit=70, flush=0) → treated as 64 ones, size_error=1. Also (0xFF,4) appends 0xF only.
- Reset mid-operation: 20 bits pending and 3 words queued, pulse reset_n low asynchronously → out_valid=0 and total_bits=0 immediately. A following (0x1,1,flush=1) → word 0x8000000000000000, bytes=1.
